uart_tx_arbiter: RTL

//  Round-robin arbiter sharing one uart_tx byte transmitter among NREQ byte-stream clients.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Purpose: shared types for the UART transmit arbiter and related UART glue.
//   arb_state_e : arbiter FSM states
//   uart_byte_t : one UART payload byte
package uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WD_W   = 24;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef logic [BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Purpose: combinational round-robin pick. Returns the first set bit of valid_i
// scanning ptr_i, ptr_i+1, ... wrapping at N (wrap by compare, so any N works).
// Ports:
//   valid_i [N]  request vector
//   ptr_i   [IW] index with highest priority
//   any_o        at least one request present
//   idx_o   [IW] winning index (0 when any_o=0)
module uart_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  // Priority scan starting at ptr_i; first hit wins.
  always_comb begin
    int unsigned cand;
    cand  = 0;
    any_o = 1'b0;
    idx_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!any_o && valid_i[IW'(cand)]) begin
        any_o = 1'b1;
        idx_o = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter sharing one uart_tx byte transmitter among NREQ
// byte-stream clients. One byte is accepted per grant, a one-cycle start strobe
// goes to the transmitter, and the arbiter waits for frame completion. A
// watchdog aborts a frame whose completion never arrives.
// Optional feature: define UART_TX_ARB_LOCK_EN to add req_lock, which keeps the
// current winner at top priority after its frame (packet transfers).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid[N]   requester i has a byte pending (held until req_ready)
//   req_data[8N]   byte of requester i at [8*i+7:8*i]
//   req_lock[N]    (UART_TX_ARB_LOCK_EN only) keep priority after frame
//   req_ready[N]   one-cycle accept pulse to the granted requester
//   tx_data[8]     byte to the transmitter
//   tx_start       one-cycle start strobe to the transmitter
//   tx_done        frame-complete pulse from the transmitter
//   busy           frame in flight
//   grant_id       index of last granted requester
//   timeout_err    sticky watchdog flag, cleared only by rst
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned     NREQ        = 4,
  parameter logic [WD_W-1:0] TIMEOUT_CYC = 24'hFFFFFF,
  localparam int unsigned    GW          = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*BYTE_W-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NREQ-1:0]        req_lock,
`endif
  output logic [NREQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_start,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [GW-1:0]          grant_id,
  output logic                   timeout_err
);

  arb_state_e      state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  uart_byte_t      data_q, data_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic            pick_any;
  logic [GW-1:0]   pick_idx;
  uart_byte_t      pick_data;
  logic [GW-1:0]   rr_next;
  logic            wd_hit;

  uart_rr_pick #(
    .N  (NREQ),
    .IW (GW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .any_o   (pick_any),
    .idx_o   (pick_idx)
  );

  assign pick_data = req_data[BYTE_W*32'(pick_idx) +: BYTE_W];

  // Pointer after a finished/aborted frame; wrap by compare for non-pow2 NREQ.
  always_comb begin
    rr_next = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
`ifdef UART_TX_ARB_LOCK_EN
    if (req_lock[grant_q]) rr_next = grant_q;
`endif
  end

  assign wd_hit = (TIMEOUT_CYC != '0) && (wd_q == TIMEOUT_CYC - WD_W'(1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    ready_d  = '0;
    start_d  = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    wd_d     = wd_q;
    case (state_q)
      ARB_IDLE: begin
        busy_d = 1'b0;
        wd_d   = '0;
        if (pick_any) begin
          ready_d = NREQ'(1) << pick_idx;
          start_d = 1'b1;
          data_d  = pick_data;
          grant_d = pick_idx;
          busy_d  = 1'b1;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // tx_done coinciding with our own start strobe is stale; ignore it.
        if (tx_done && !start_q) begin
          rr_ptr_d = rr_next;
          busy_d   = 1'b0;
          state_d  = ARB_IDLE;
        end else if (wd_hit) begin
          err_d    = 1'b1;
          rr_ptr_d = rr_next;
          busy_d   = 1'b0;
          state_d  = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      ready_q  <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  assign req_ready   = ready_q;
  assign tx_data     = data_q;
  assign tx_start    = start_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign timeout_err = err_q;

endmodule
